// File: rtl/mem_port_arbiter_if.sv
// Pipeline request ports and unified-memory bus of mem_port_arbiter.
// The arbiter connects through the slave modport; the pipeline/memory side uses master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                IF_Req;
    logic [ADDR_W-1:0]   IF_Addr;
    logic                IF_Flush;
    logic                MEM_Req;
    logic                MEM_Write;
    logic [ADDR_W-1:0]   MEM_Addr;
    logic [DATA_W-1:0]   MEM_WData;
    logic [DATA_W/8-1:0] MEM_BE;
    logic [DATA_W-1:0]   IF_Data;
    logic                IF_Valid;
    logic [DATA_W-1:0]   MEM_RData;
    logic                MEM_Valid;
    logic                IF_Wait;
    logic                MEM_Wait;
    logic                Bus_Error;
    logic                Mem_Req;
    logic                Mem_We;
    logic [ADDR_W-1:0]   Mem_Addr;
    logic [DATA_W-1:0]   Mem_WData;
    logic [DATA_W/8-1:0] Mem_BE;
    logic                Mem_Ready;
    logic [DATA_W-1:0]   Mem_RData;

    modport slave (
        input  IF_Req, IF_Addr, IF_Flush, MEM_Req, MEM_Write, MEM_Addr, MEM_WData, MEM_BE,
        input  Mem_Ready, Mem_RData,
        output IF_Data, IF_Valid, MEM_RData, MEM_Valid, IF_Wait, MEM_Wait, Bus_Error,
        output Mem_Req, Mem_We, Mem_Addr, Mem_WData, Mem_BE
    );

    modport master (
        output IF_Req, IF_Addr, IF_Flush, MEM_Req, MEM_Write, MEM_Addr, MEM_WData, MEM_BE,
        output Mem_Ready, Mem_RData,
        input  IF_Data, IF_Valid, MEM_RData, MEM_Valid, IF_Wait, MEM_Wait, Bus_Error,
        input  Mem_Req, Mem_We, Mem_Addr, Mem_WData, Mem_BE
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data load/store,
// with data priority, fetch kill on redirect and a per-access timeout.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WAIT_LIMIT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    mem_port_arbiter_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2
    } state_t;

    state_t            state_r, next_state_s;
    logic [CNT_W-1:0]  wait_cnt_r, wait_cnt_s;
    logic              kill_r, kill_s;
    logic              mem_req_r, mem_req_s;
    logic              mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic [BE_W-1:0]   mem_be_r, mem_be_s;
    logic [DATA_W-1:0] if_data_r, if_data_s;
    logic              if_valid_r, if_valid_s;
    logic [DATA_W-1:0] mem_rdata_r, mem_rdata_s;
    logic              mem_valid_r, mem_valid_s;
    logic              bus_error_r, bus_error_s;

    logic busy_s, done_s, abort_s, mem_go_s, if_go_s, kill_now_s;

    // A requester whose Valid is high this cycle still holds a stale Req and is masked.
    assign busy_s     = (state_r != IDLE);
    assign done_s     = busy_s & bus.Mem_Ready;
    assign abort_s    = busy_s & ~bus.Mem_Ready & (wait_cnt_r == CNT_LAST);
    assign mem_go_s   = (state_r == IDLE) & bus.MEM_Req & ~mem_valid_r;
    assign if_go_s    = (state_r == IDLE) & ~mem_go_s & bus.IF_Req & ~if_valid_r;
    assign kill_now_s = kill_r | ((state_r == I_ACC) & bus.IF_Flush);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (mem_go_s) begin
                    next_state_s = D_ACC;
                end else if (if_go_s) begin
                    next_state_s = I_ACC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            D_ACC, I_ACC: begin
                if (done_s || abort_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs, wait counter and kill flag
    always_comb begin
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_be_s    = mem_be_r;
        if_data_s   = if_data_r;
        mem_rdata_s = mem_rdata_r;
        if_valid_s  = 1'b0;
        mem_valid_s = 1'b0;
        bus_error_s = bus_error_r | abort_s;
        wait_cnt_s  = wait_cnt_r;
        kill_s      = kill_r;
        case (state_r)
            IDLE: begin
                wait_cnt_s = '0;
                kill_s     = 1'b0;
                if (mem_go_s) begin
                    mem_req_s   = 1'b1;
                    mem_we_s    = bus.MEM_Write;
                    mem_addr_s  = bus.MEM_Addr;
                    mem_wdata_s = bus.MEM_WData;
                    mem_be_s    = bus.MEM_BE;
                end else if (if_go_s) begin
                    mem_req_s  = 1'b1;
                    mem_we_s   = 1'b0;
                    mem_addr_s = bus.IF_Addr;
                    mem_be_s   = '1;
                end else begin
                    mem_req_s = 1'b0;
                end
            end
            D_ACC, I_ACC: begin
                if (done_s || abort_s) begin
                    mem_req_s  = 1'b0;
                    wait_cnt_s = '0;
                    kill_s     = 1'b0;
                    if (state_r == D_ACC) begin
                        mem_valid_s = 1'b1;
                        if (abort_s) begin
                            mem_rdata_s = '0;
                        end else if (!mem_we_r) begin
                            mem_rdata_s = bus.Mem_RData;
                        end else begin
                            mem_rdata_s = mem_rdata_r;
                        end
                    end else if (!kill_now_s) begin
                        if_valid_s = 1'b1;
                        if_data_s  = abort_s ? '0 : bus.Mem_RData;
                    end else begin
                        if_data_s = if_data_r;
                    end
                end else begin
                    wait_cnt_s = wait_cnt_r + CNT_W'(1);
                    kill_s     = kill_now_s;
                end
            end
            default: begin
                mem_req_s  = 1'b0;
                wait_cnt_s = '0;
                kill_s     = 1'b0;
            end
        endcase
    end

    // Output, counter and kill-flag registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt_r  <= '0;
            kill_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_be_r    <= '0;
            if_data_r   <= '0;
            if_valid_r  <= 1'b0;
            mem_rdata_r <= '0;
            mem_valid_r <= 1'b0;
            bus_error_r <= 1'b0;
        end else begin
            wait_cnt_r  <= wait_cnt_s;
            kill_r      <= kill_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_be_r    <= mem_be_s;
            if_data_r   <= if_data_s;
            if_valid_r  <= if_valid_s;
            mem_rdata_r <= mem_rdata_s;
            mem_valid_r <= mem_valid_s;
            bus_error_r <= bus_error_s;
        end
    end

    assign bus.Mem_Req   = mem_req_r;
    assign bus.Mem_We    = mem_we_r;
    assign bus.Mem_Addr  = mem_addr_r;
    assign bus.Mem_WData = mem_wdata_r;
    assign bus.Mem_BE    = mem_be_r;
    assign bus.IF_Data   = if_data_r;
    assign bus.IF_Valid  = if_valid_r;
    assign bus.MEM_RData = mem_rdata_r;
    assign bus.MEM_Valid = mem_valid_r;
    assign bus.Bus_Error = bus_error_r;
    assign bus.IF_Wait   = bus.IF_Req & ~if_valid_r;
    assign bus.MEM_Wait  = bus.MEM_Req & ~mem_valid_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: random fetch/data requesters, flushes, resets and a
// variable-latency memory, checked cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int WAIT_LIMIT = 16;
    localparam int N_CYCLES   = 4000;

    logic CLK = 1'b0;
    logic RST;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Memory contents and responder state
    logic [31:0] mem_arr [16];
    int          lat_tab [8] = '{0, 0, 1, 2, 3, 15, 16, 21};
    bit          r_active;
    int          r_wait;
    int          r_lat;

    // Requester bookkeeping
    bit if_seen_valid;
    bit mem_seen_valid;

    // Reference model: what the bus and the pipeline should see this cycle
    bit          m_ok, m_fresh, m_busy, m_is_data, m_we, m_kill, m_berr;
    bit          m_if_valid, m_mem_valid;
    int          m_waits;
    logic [31:0] m_addr, m_wdata, m_if_data, m_mem_rdata;
    logic [3:0]  m_be;

    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        base = ($urandom_range(0, 1) == 0) ? 32'h0040_0000 : 32'h1001_0000;
        return base | {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    endfunction

    task automatic drive_phase(input int cyc);
        RST = (cyc < 2) || ((bus.Mem_Req === 1'b1) && ($urandom_range(0, 149) == 0));

        if (bus.IF_Req && if_seen_valid) begin
            bus.IF_Req = 1'b0;
        end else if (!bus.IF_Req && ($urandom_range(0, 2) == 0)) begin
            bus.IF_Req  = 1'b1;
            bus.IF_Addr = rand_addr();
        end
        bus.IF_Flush = ($urandom_range(0, 9) == 0);
        if (bus.IF_Flush && bus.IF_Req) bus.IF_Addr = rand_addr();

        if (bus.MEM_Req && mem_seen_valid) begin
            bus.MEM_Req = 1'b0;
        end else if (!bus.MEM_Req && ($urandom_range(0, 3) == 0)) begin
            bus.MEM_Req   = 1'b1;
            bus.MEM_Write = 1'($urandom_range(0, 1));
            bus.MEM_Addr  = rand_addr();
            bus.MEM_WData = $urandom;
            bus.MEM_BE    = 4'($urandom_range(0, 15));
        end

        if (bus.Mem_Req === 1'b1) begin
            if (!r_active) begin
                r_active = 1'b1;
                r_wait   = 0;
                r_lat    = lat_tab[$urandom_range(0, 7)];
            end
            bus.Mem_Ready = (r_wait >= r_lat);
            bus.Mem_RData = bus.Mem_Ready ? mem_arr[bus.Mem_Addr[5:2]] : $urandom;
        end else begin
            r_active      = 1'b0;
            bus.Mem_Ready = 1'($urandom_range(0, 1));
            bus.Mem_RData = $urandom;
        end
    endtask

    task automatic compare_phase();
        check_val("mem_req", bus.Mem_Req, m_busy);
        if (m_busy) begin
            check_val("mem_addr", bus.Mem_Addr, m_addr);
            check_val("mem_we", bus.Mem_We, m_we);
            check_val("mem_be", bus.Mem_BE, m_be);
            if (m_is_data) check_val("mem_wdata", bus.Mem_WData, m_wdata);
        end
        if (m_fresh) begin
            check_val("rst_mem_addr", bus.Mem_Addr, 32'd0);
            check_val("rst_mem_wdata", bus.Mem_WData, 32'd0);
            check_val("rst_mem_be_we", {bus.Mem_BE, bus.Mem_We}, 5'd0);
        end
        check_val("if_valid", bus.IF_Valid, m_if_valid);
        check_val("mem_valid", bus.MEM_Valid, m_mem_valid);
        check_val("if_data", bus.IF_Data, m_if_data);
        check_val("mem_rdata", bus.MEM_RData, m_mem_rdata);
        check_val("bus_error", bus.Bus_Error, m_berr);
        check_val("if_wait", bus.IF_Wait, bus.IF_Req & ~m_if_valid);
        check_val("mem_wait", bus.MEM_Wait, bus.MEM_Req & ~m_mem_valid);
    endtask

    task automatic model_step();
        bit          nv_if, nv_mem, kill_eff, fin, aborted;
        logic [31:0] rd;
        nv_if   = 1'b0;
        nv_mem  = 1'b0;
        fin     = 1'b0;
        aborted = 1'b0;
        rd      = bus.Mem_RData;
        m_fresh = 1'b0;
        if (RST) begin
            m_ok        = 1'b1;
            m_fresh     = 1'b1;
            m_busy      = 1'b0;
            m_waits     = 0;
            m_kill      = 1'b0;
            m_berr      = 1'b0;
            m_if_data   = 32'd0;
            m_mem_rdata = 32'd0;
        end else if (m_ok && m_busy) begin
            kill_eff = m_kill || (!m_is_data && bus.IF_Flush);
            if (bus.Mem_Ready) begin
                fin = 1'b1;
            end else if (m_waits + 1 == WAIT_LIMIT) begin
                fin     = 1'b1;
                aborted = 1'b1;
            end else begin
                m_waits++;
                m_kill = kill_eff;
            end
            if (fin) begin
                m_busy = 1'b0;
                m_kill = 1'b0;
                if (aborted) m_berr = 1'b1;
                if (m_is_data) begin
                    nv_mem = 1'b1;
                    if (aborted) m_mem_rdata = 32'd0;
                    else if (!m_we) m_mem_rdata = rd;
                end else if (!kill_eff) begin
                    nv_if     = 1'b1;
                    m_if_data = aborted ? 32'd0 : rd;
                end
            end
        end else if (m_ok) begin
            m_waits = 0;
            m_kill  = 1'b0;
            if (bus.MEM_Req && !m_mem_valid) begin
                m_busy    = 1'b1;
                m_is_data = 1'b1;
                m_we      = bus.MEM_Write;
                m_addr    = bus.MEM_Addr;
                m_wdata   = bus.MEM_WData;
                m_be      = bus.MEM_BE;
            end else if (bus.IF_Req && !m_if_valid) begin
                m_busy    = 1'b1;
                m_is_data = 1'b0;
                m_we      = 1'b0;
                m_addr    = bus.IF_Addr;
                m_be      = 4'hF;
            end
        end
        m_if_valid  = nv_if;
        m_mem_valid = nv_mem;
    endtask

    task automatic sample_phase();
        if (m_ok) compare_phase();
        if (bus.Mem_Req === 1'b1 && bus.Mem_Ready === 1'b0) r_wait++;
        if (bus.Mem_Req === 1'b1 && bus.Mem_Ready === 1'b1 && bus.Mem_We === 1'b1) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.Mem_BE[b]) mem_arr[bus.Mem_Addr[5:2]][8*b +: 8] = bus.Mem_WData[8*b +: 8];
            end
        end
        if_seen_valid  = (bus.IF_Valid === 1'b1);
        mem_seen_valid = (bus.MEM_Valid === 1'b1);
        model_step();
    endtask

    initial begin
        RST           = 1'b1;
        bus.IF_Req    = 1'b0;
        bus.IF_Addr   = 32'd0;
        bus.IF_Flush  = 1'b0;
        bus.MEM_Req   = 1'b0;
        bus.MEM_Write = 1'b0;
        bus.MEM_Addr  = 32'd0;
        bus.MEM_WData = 32'd0;
        bus.MEM_BE    = 4'd0;
        bus.Mem_Ready = 1'b0;
        bus.Mem_RData = 32'd0;
        for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;
        r_active       = 1'b0;
        r_wait         = 0;
        r_lat          = 0;
        if_seen_valid  = 1'b0;
        mem_seen_valid = 1'b0;
        m_ok           = 1'b0;
        m_fresh        = 1'b0;
        m_busy         = 1'b0;
        m_is_data      = 1'b0;
        m_we           = 1'b0;
        m_kill         = 1'b0;
        m_berr         = 1'b0;
        m_if_valid     = 1'b0;
        m_mem_valid    = 1'b0;
        m_waits        = 0;
        m_addr         = 32'd0;
        m_wdata        = 32'd0;
        m_be           = 4'd0;
        m_if_data      = 32'd0;
        m_mem_rdata    = 32'd0;
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge CLK);
            #1;
            drive_phase(cyc);
            @(negedge CLK);
            sample_phase();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
